dcache_direct_mapped: RTL

- Write-back, direct-mapped data cache between the CPU load/store path (8-bit byte address, 8-bit data) and the 32-bit-word data memory (6-bit word address, busywait handshake).
- Hits complete with no stall.
- Misses stall the CPU via busywait while the block is written back if dirty, then refilled.
- Geometry: 8 blocks x 4 bytes; 3-bit tag, 3-bit index, 2-bit offset.

---
 rtl/dcache_direct_mapped.sv | 116 +++++++++++
 1 files changed

// File: rtl/dcache_direct_mapped.sv
// Write-back, direct-mapped data cache: 8 blocks x 4 bytes between the CPU byte
// port and a 32-bit word memory, stalling the CPU through busywait on a miss.
module dcache_direct_mapped (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

    state_e      state_q, state_d;
    logic        first_q;
    logic [31:0] data_q  [8];
    logic [2:0]  tag_q   [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic        mem_read_q, mem_write_q;
    logic [5:0]  mem_address_q;
    logic [31:0] mem_writedata_q;

    logic [2:0]  tag_in;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic        access;
    logic        hit;

    assign tag_in = address[7:5];
    assign index  = address[4:2];
    assign offset = address[1:0];
    assign access = read ^ write;
    assign hit    = valid_q[index] && (tag_q[index] == tag_in);

    assign readdata      = data_q[index][{offset, 3'b000} +: 8];
    // Reset is folded in so the CPU sees no stall while reset is asserted.
    assign busywait      = !reset && access && !(state_q == IDLE && hit);
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    state_d = dirty_q[index] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!first_q && !mem_busywait) state_d = FETCH;
            end
            FETCH: begin
                if (!first_q && !mem_busywait) state_d = UPDATE;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            first_q         <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            // The memory raises busywait combinationally, so the entry edge is ignored.
            first_q     <= (state_d != state_q);
            mem_read_q  <= (state_d == FETCH);
            mem_write_q <= (state_d == WRITEBACK);
            if (state_d == WRITEBACK) begin
                mem_address_q   <= {tag_q[index], index};
                mem_writedata_q <= data_q[index];
            end else if (state_d == FETCH) begin
                mem_address_q   <= address[7:2];
            end
        end
    end

    // NOTE: the storage array is reset because a reset must discard every line, dirty or not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (state_q == UPDATE) begin
            data_q[index]  <= mem_readdata;
            tag_q[index]   <= tag_in;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (state_q == IDLE && write && !read && hit) begin
            data_q[index][{offset, 3'b000} +: 8] <= writedata;
            dirty_q[index] <= 1'b1;
        end
    end

endmodule
